// File: rtl/axis_master.sv
// Single-beat AXI4-Stream master.
// A 0->1 edge on send captures data into a one-entry pending buffer. The
// buffered word moves to the output registers when the output is idle. It is
// held there until the sink accepts it. Each accepted beat is a complete
// one-word packet, and finish pulses for one cycle after the handshake.
module axis_master #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  send,
  input  logic                  tready,
  output logic                  tvalid,
  output logic                  tlast,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  finish
);

  // Delayed copy of send for edge detection. It resets to 1 so that a send
  // level held high through reset does not count as a fresh request.
  logic                  r_send_q;

  // One-entry pending buffer.
  logic                  r_pend_valid;
  logic [DATA_WIDTH-1:0] r_pend_data;

  // Output stage registers.
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_finish;

  logic                  w_rise;
  logic                  w_capture;
  logic                  w_handshake;
  logic                  w_load;

  assign w_rise      = send & ~r_send_q;
  // A request is dropped silently when the buffer is already occupied.
  assign w_capture   = w_rise & ~r_pend_valid;
  assign w_handshake = r_tvalid & tready;
  // The output only loads while idle. The buffer is therefore never moved
  // out on a handshake edge, which forces at least one idle cycle between
  // beats.
  assign w_load      = ~r_tvalid & r_pend_valid;

  // Track the previous send level for rising-edge detection.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_send_q <= 1'b1;
    end else begin
      r_send_q <= send;
    end
  end

  // The pending buffer fills on an accepted rise and empties when its word
  // moves to the output. The two cases are exclusive: filling needs an empty
  // buffer, and emptying needs a full one.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
    end else if (w_capture) begin
      r_pend_valid <= 1'b1;
      r_pend_data  <= data;
    end else if (w_load) begin
      r_pend_valid <= 1'b0;
    end
  end

  // The output stage loads from the buffer when idle and holds while
  // stalled. It retires the beat on a handshake. tdata keeps its last value
  // after the handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tlast  <= 1'b1;
      r_tdata  <= r_pend_data;
    end else if (w_handshake) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  // finish is a one-cycle pulse in the cycle after each accepted beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_finish <= 1'b0;
    end else begin
      r_finish <= w_handshake;
    end
  end

  assign tvalid = r_tvalid;
  assign tlast  = r_tlast;
  assign tdata  = r_tdata;
  assign finish = r_finish;

endmodule

// File: tb/tb_axis_master.sv
// Directed testbench for axis_master: reset, single word, back-to-back,
// backpressure, overflow and reset in the middle of a transfer.
module tb_axis_master;

  logic        aclk;
  logic        areset;
  logic [31:0] data;
  logic        send;
  logic        tready;
  logic        tvalid;
  logic        tlast;
  logic [31:0] tdata;
  logic        finish;

  int total;
  int bad;
  int fin_cnt;

  axis_master #(.DATA_WIDTH(32)) dut (
    .aclk   (aclk),
    .areset (areset),
    .data   (data),
    .send   (send),
    .tready (tready),
    .tvalid (tvalid),
    .tlast  (tlast),
    .tdata  (tdata),
    .finish (finish)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance one clock edge, then settle 1 ns before the next sample. Each
  // finish pulse is counted and logged as one completed transaction.
  task automatic step();
    @(posedge aclk);
    #1;
    if (finish === 1'b1) begin
      fin_cnt++;
      $display("transfer finished: tdata=%08h", tdata);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; send = 1'b0; tready = 1'b0; data = 32'h0;
    repeat (5) step();
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%0h want=0", tvalid); end
    total++; if (tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%0h want=0", tlast); end
    total++; if (tdata !== 32'h0) begin bad++; $display("FAIL rst_tdata got=%08h want=00000000", tdata); end
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL rst_finish got=%0h want=0", finish); end
    // A send level held high across reset release must not start a transfer.
    send = 1'b1; data = 32'hdead_beef; tready = 1'b1;
    step();
    areset = 1'b0;
    fin_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rst_send_held cyc=%0d tvalid got=%0h want=0", i, tvalid); end
    end
    total++; if (fin_cnt !== 0) begin bad++; $display("FAIL rst_send_held_finish got=%0d want=0", fin_cnt); end
    send = 1'b0;
    step();
  endtask

  task automatic test_single();
    fin_cnt = 0;
    tready = 1'b1; data = 32'haaaa_bbbb; send = 1'b1;
    step();   // rise sampled: the word goes into the buffer
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL single_pre tvalid got=%0h want=0", tvalid); end
    data = 32'h1234_5678;   // a change after capture must not reach tdata
    step();   // the output loads
    send = 1'b0;
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL single_tvalid got=%0h want=1", tvalid); end
    total++; if (tdata !== 32'haaaa_bbbb) begin bad++; $display("FAIL single_tdata got=%08h want=aaaabbbb", tdata); end
    total++; if (tlast !== 1'b1) begin bad++; $display("FAIL single_tlast got=%0h want=1", tlast); end
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL single_finish_early got=%0h want=0", finish); end
    step();   // handshake
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL single_done tvalid got=%0h want=0", tvalid); end
    total++; if (tlast !== 1'b0) begin bad++; $display("FAIL single_done tlast got=%0h want=0", tlast); end
    total++; if (finish !== 1'b1) begin bad++; $display("FAIL single_finish got=%0h want=1", finish); end
    total++; if (tdata !== 32'haaaa_bbbb) begin bad++; $display("FAIL single_tdata_kept got=%08h want=aaaabbbb", tdata); end
    step();
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL single_finish_len got=%0h want=0", finish); end
    total++; if (fin_cnt !== 1) begin bad++; $display("FAIL single_finish_count got=%0d want=1", fin_cnt); end
  endtask

  task automatic test_back_to_back();
    fin_cnt = 0;
    tready = 1'b1; data = 32'haaaa_bbbb; send = 1'b1;
    step();   // capture of the first word
    send = 1'b0;
    step();   // the first word loads
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL b2b_first tvalid got=%0h want=1", tvalid); end
    data = 32'hcccc_dddd; send = 1'b1;
    step();   // handshake of the first word and capture of the second
    send = 1'b0;
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL b2b_gap tvalid got=%0h want=0", tvalid); end
    total++; if (finish !== 1'b1) begin bad++; $display("FAIL b2b_finish1 got=%0h want=1", finish); end
    step();   // the second word loads
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL b2b_second tvalid got=%0h want=1", tvalid); end
    total++; if (tdata !== 32'hcccc_dddd) begin bad++; $display("FAIL b2b_second tdata got=%08h want=ccccdddd", tdata); end
    step();   // handshake of the second word
    total++; if (finish !== 1'b1) begin bad++; $display("FAIL b2b_finish2 got=%0h want=1", finish); end
    step();
    step();
    total++; if (fin_cnt !== 2) begin bad++; $display("FAIL b2b_finish_count got=%0d want=2", fin_cnt); end
  endtask

  task automatic test_backpressure();
    fin_cnt = 0;
    tready = 1'b0; data = 32'h5a5a_5a5a; send = 1'b1;
    step();
    send = 1'b0; data = 32'h0;
    step();   // the output loads while the sink is stalled
    for (int i = 0; i < 6; i++) begin
      total++; if (tvalid !== 1'b1 || tlast !== 1'b1 || tdata !== 32'h5a5a_5a5a || finish !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%0h l=%0h d=%08h f=%0h want v=1 l=1 d=5a5a5a5a f=0", i, tvalid, tlast, tdata, finish);
      end
      step();
    end
    tready = 1'b1;
    step();   // handshake
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL bp_release tvalid got=%0h want=0", tvalid); end
    total++; if (finish !== 1'b1) begin bad++; $display("FAIL bp_finish got=%0h want=1", finish); end
    step();
    total++; if (fin_cnt !== 1) begin bad++; $display("FAIL bp_finish_count got=%0d want=1", fin_cnt); end
  endtask

  task automatic test_overflow();
    fin_cnt = 0;
    tready = 1'b0;
    data = 32'h1; send = 1'b1; step();   // word 1 captured
    send = 1'b0; step();                 // word 1 loads; the output stalls
    data = 32'h2; send = 1'b1; step();   // word 2 queued
    send = 1'b0; step();
    data = 32'h3; send = 1'b1; step();   // word 3 dropped because the buffer is full
    send = 1'b0; step();
    total++; if (tvalid !== 1'b1 || tdata !== 32'h1) begin bad++; $display("FAIL ovf_first got v=%0h d=%08h want v=1 d=00000001", tvalid, tdata); end
    tready = 1'b1;
    step();   // handshake of word 1
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL ovf_gap tvalid got=%0h want=0", tvalid); end
    step();   // word 2 loads
    total++; if (tvalid !== 1'b1 || tdata !== 32'h2) begin bad++; $display("FAIL ovf_second got v=%0h d=%08h want v=1 d=00000002", tvalid, tdata); end
    step();   // handshake of word 2
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL ovf_dropped cyc=%0d tvalid got=%0h want=0 d=%08h", i, tvalid, tdata); end
    end
    total++; if (fin_cnt !== 2) begin bad++; $display("FAIL ovf_finish_count got=%0d want=2", fin_cnt); end
  endtask

  task automatic test_reset_mid();
    tready = 1'b0;
    data = 32'h77; send = 1'b1; step();
    send = 1'b0; step();
    data = 32'h88; send = 1'b1; step();  // a second word waits in the buffer
    send = 1'b0;
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL mid_pre tvalid got=%0h want=1", tvalid); end
    #2 areset = 1'b1;
    #1;
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL mid_async tvalid got=%0h want=0", tvalid); end
    total++; if (tdata !== 32'h0) begin bad++; $display("FAIL mid_async tdata got=%08h want=00000000", tdata); end
    step();
    areset = 1'b0; tready = 1'b1;
    fin_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL mid_after cyc=%0d tvalid got=%0h want=0", i, tvalid); end
    end
    total++; if (fin_cnt !== 0) begin bad++; $display("FAIL mid_finish_count got=%0d want=0", fin_cnt); end
    data = 32'h99; send = 1'b1; step();
    send = 1'b0; step();
    total++; if (tvalid !== 1'b1 || tdata !== 32'h99) begin bad++; $display("FAIL mid_new got v=%0h d=%08h want v=1 d=00000099", tvalid, tdata); end
    step();
    total++; if (finish !== 1'b1) begin bad++; $display("FAIL mid_new_finish got=%0h want=1", finish); end
  endtask

  initial begin
    total = 0; bad = 0; fin_cnt = 0;
    areset = 1'b1; send = 1'b0; tready = 1'b0; data = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
